// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, frame geometry
// and default bit timing.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 87;
  localparam int unsigned DATA_BITS            = 8;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input; RESET_VAL sets the
// value both flops take on reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_D,
  output logic o_Q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = i_D;
    sync_d = meta_q;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_Q = sync_q;

endmodule

// File: rtl/uart_rx_framed.sv
// UART receiver with start-glitch rejection, stop-bit framing check, break
// hold-off and a valid/ready output with overrun pulse.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Valid,
  input  logic       i_Rx_Ready,
  output logic       o_Frame_Err,
`ifdef UART_RX_PARITY_EN
  output logic       o_Parity_Err,
`endif
  output logic       o_Overrun,
  output logic       o_Rx_Active
);

  localparam int unsigned HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_D     (i_Rx_Serial),
    .o_Q     (rx)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 done_q, done_d;
  logic                 done_ferr_q, done_ferr_d;
  logic                 par_q, par_d;
  logic [7:0]           byte_q, byte_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    done_d      = 1'b0;
    done_ferr_d = done_ferr_q;
    par_d       = par_q;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx;
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = rx;
          state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          done_d      = 1'b1;
          done_ferr_d = ~rx;
          state_d     = rx ? RX_IDLE : RX_BREAK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_BREAK: begin
        cnt_d = '0;
        if (rx) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Completion is handled one cycle after the stop sample; an accept in that
  // same cycle frees the holding register so the new byte can replace it.
  always_comb begin
    byte_d  = byte_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    ovr_d   = 1'b0;
    if (valid_q && i_Rx_Ready) valid_d = 1'b0;
    if (done_q) begin
      if (!valid_q || i_Rx_Ready) begin
        byte_d  = shift_q;
        ferr_d  = done_ferr_q;
        perr_d  = ^{shift_q, par_q};
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      done_q      <= 1'b0;
      done_ferr_q <= 1'b0;
      par_q       <= 1'b0;
      byte_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      perr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      done_ferr_q <= done_ferr_d;
      par_q       <= par_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      perr_q      <= perr_d;
      ovr_q       <= ovr_d;
    end
  end

  assign o_Rx_Byte   = byte_q;
  assign o_Rx_Valid  = valid_q;
  assign o_Frame_Err = ferr_q;
  assign o_Overrun   = ovr_q;
  assign o_Rx_Active = (state_q != RX_IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_Parity_Err = perr_q;
`else
  logic unused_perr;
  assign unused_perr = perr_q;
`endif

endmodule
